ft_bus_scheduler: RTL and testbench

Bus master for the FT601 245-synchronous FIFO interface, clocked by the FTDI clock at 100 MHz. It shares the single bidirectional DATA/BE bus between two requesters: the TX stream (FPGA to host, fed by a first-word-fall-through FIFO) and the RX stream (host to FPGA, sinking into a FIFO). It sequences WR_N/RD_N/OE_N, bus turnaround and the pad drive enable, and enforces round-robin burst fairness. The tristate pads sit in the top level; this block only provides separate in/out/enable signals.

---
 rtl/ft_bus_scheduler.sv | 176 +++++++++++++++++
 tb/tb_ft_bus_scheduler.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft_bus_scheduler.sv
// FT601 245-synchronous FIFO bus master: round-robin TX/RX bursts with turnaround and OE handover.
// Define FT_SCHED_STATS_EN to add the tx_words_out / rx_words_out accepted-word counters.
module ft_bus_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = 4,
    parameter int MAX_BURST  = 256,
    parameter int CNT_W      = 9
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  txe_n_in,
    input  logic                  rxf_n_in,
    output logic                  wr_n_out,
    output logic                  rd_n_out,
    output logic                  oe_n_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [BE_WIDTH-1:0]   be_out,
    output logic                  data_oe_out,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [BE_WIDTH-1:0]   be_in,
    input  logic [DATA_WIDTH-1:0] tx_data_in,
    input  logic [BE_WIDTH-1:0]   tx_be_in,
    input  logic                  tx_valid_in,
    output logic                  tx_pop_out,
    output logic [DATA_WIDTH-1:0] rx_data_out,
    output logic [BE_WIDTH-1:0]   rx_be_out,
    output logic                  rx_valid_out,
    input  logic                  rx_full_in
`ifdef FT_SCHED_STATS_EN
    ,
    output logic [31:0]           tx_words_out,
    output logic [31:0]           rx_words_out
`endif
);

    // IDLE: arbitrate | TX_BURST: FPGA drives | RX_OE: chip takes bus | RX_BURST: read | TURN: gap
    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_BURST,
        S_RX_OE,
        S_RX_BURST,
        S_TURN
    } state_t;

    localparam logic [CNT_W-1:0] LP_MAX  = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(MAX_BURST - 1);

    state_t                r_state;
    state_t                w_next;
    logic                  r_last_rx;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_rx_valid;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic [BE_WIDTH-1:0]   r_rx_be;

    logic w_tx_req;
    logic w_rx_req;
    logic w_grant_tx;
    logic w_grant_rx;
    logic w_tx_acc;
    logic w_rx_take;
    logic w_cnt_last;

    assign w_tx_req   = tx_valid_in & ~txe_n_in;
    assign w_rx_req   = ~rxf_n_in & ~rx_full_in;
    assign w_cnt_last = (r_cnt == LP_LAST);

    always_comb begin
        w_next      = r_state;
        wr_n_out    = 1'b1;
        rd_n_out    = 1'b1;
        oe_n_out    = 1'b1;
        data_oe_out = 1'b0;
        w_tx_acc    = 1'b0;
        w_rx_take   = 1'b0;
        w_grant_tx  = 1'b0;
        w_grant_rx  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tx_req && (!w_rx_req || r_last_rx)) begin
                    w_grant_tx = 1'b1;
                    w_next     = S_TX_BURST;
                end else if (w_rx_req) begin
                    w_grant_rx = 1'b1;
                    w_next     = S_RX_OE;
                end
            end
            S_TX_BURST: begin
                data_oe_out = 1'b1;
                wr_n_out    = ~tx_valid_in;
                w_tx_acc    = tx_valid_in & ~txe_n_in;
                // when no word is accepted the burst is over anyway, so the
                // terminal count only matters on an accepting edge
                if (!w_tx_acc || w_cnt_last) begin
                    w_next = S_TURN;
                end
            end
            S_RX_OE: begin
                oe_n_out = 1'b0;
                w_next   = S_RX_BURST;
            end
            S_RX_BURST: begin
                oe_n_out  = 1'b0;
                rd_n_out  = rx_full_in;
                w_rx_take = ~rx_full_in & ~rxf_n_in;
                if (!w_rx_take || w_cnt_last) begin
                    w_next = S_TURN;
                end
            end
            S_TURN: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign tx_pop_out   = w_tx_acc;
    assign data_out     = tx_data_in;
    assign be_out       = tx_be_in;
    assign rx_valid_out = r_rx_valid;
    assign rx_data_out  = r_rx_data;
    assign rx_be_out    = r_rx_be;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state    <= S_IDLE;
            r_last_rx  <= 1'b1;
            r_cnt      <= '0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_rx_be    <= '0;
        end else begin
            r_state    <= w_next;
            r_rx_valid <= w_rx_take;
            if (w_rx_take) begin
                r_rx_data <= data_in;
                r_rx_be   <= be_in;
            end
            if (w_grant_tx) begin
                r_last_rx <= 1'b0;
            end else if (w_grant_rx) begin
                r_last_rx <= 1'b1;
            end
            if (w_grant_tx || w_grant_rx) begin
                r_cnt <= '0;
            end else if ((w_tx_acc || w_rx_take) && (r_cnt != LP_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef FT_SCHED_STATS_EN
    logic [31:0] r_tx_words;
    logic [31:0] r_rx_words;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_tx_words <= '0;
            r_rx_words <= '0;
        end else begin
            if (w_tx_acc) begin
                r_tx_words <= r_tx_words + 32'd1;
            end
            if (r_rx_valid) begin
                r_rx_words <= r_rx_words + 32'd1;
            end
        end
    end

    assign tx_words_out = r_tx_words;
    assign rx_words_out = r_rx_words;
`endif

endmodule

// File: tb/tb_ft_bus_scheduler.sv
// Bench for ft_bus_scheduler: FIFO/host environment, cycle-level protocol model, word scoreboards.
module tb_ft_bus_scheduler;
    localparam int DW   = 32;
    localparam int BW   = 4;
    localparam int MAXB = 4;
    localparam int CW   = 3;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          txe_n_in, rxf_n_in;
    logic          wr_n_out, rd_n_out, oe_n_out, data_oe_out;
    logic [DW-1:0] data_out, data_in, tx_data_in, rx_data_out;
    logic [BW-1:0] be_out, be_in, tx_be_in, rx_be_out;
    logic          tx_valid_in, tx_pop_out, rx_valid_out, rx_full_in;
`ifdef FT_SCHED_STATS_EN
    logic [31:0]   tx_words_out, rx_words_out;
`endif

    ft_bus_scheduler #(.DATA_WIDTH(DW), .BE_WIDTH(BW), .MAX_BURST(MAXB), .CNT_W(CW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .txe_n_in(txe_n_in), .rxf_n_in(rxf_n_in),
        .wr_n_out(wr_n_out), .rd_n_out(rd_n_out), .oe_n_out(oe_n_out),
        .data_out(data_out), .be_out(be_out), .data_oe_out(data_oe_out),
        .data_in(data_in), .be_in(be_in),
        .tx_data_in(tx_data_in), .tx_be_in(tx_be_in), .tx_valid_in(tx_valid_in),
        .tx_pop_out(tx_pop_out), .rx_data_out(rx_data_out), .rx_be_out(rx_be_out),
        .rx_valid_out(rx_valid_out), .rx_full_in(rx_full_in)
`ifdef FT_SCHED_STATS_EN
        , .tx_words_out(tx_words_out), .rx_words_out(rx_words_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    // environment: FPGA-side TX FIFO, host-side word source, and what each end received
    logic [31:0] tx_q[$];
    logic [3:0]  tx_be_q[$];
    logic [31:0] host_q[$];
    logic [3:0]  host_be_q[$];
    logic [31:0] tx_sent[$];
    logic [31:0] host_sent[$];
    logic [31:0] host_got[$];
    logic [31:0] fpga_got[$];

    bit          ev_tx_pop = 0, ev_host_acc = 0, ev_host_give = 0, ev_rxv = 0;
    logic [31:0] ev_host_word, ev_rx_word;

    // measurements of DUT behaviour used for the literal expectations
    int  cnt_wr_low, cnt_oe_low, cnt_rd_low, cnt_rxv, cnt_pop, cnt_doe_fall;
    bit  prev_doe = 0;
    byte seq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    always @(posedge clk_in) begin
        #1;
        if (ev_tx_pop && tx_q.size() != 0) begin
            void'(tx_q.pop_front());
            void'(tx_be_q.pop_front());
        end
        if (ev_host_acc) host_got.push_back(ev_host_word);
        if (ev_host_give && host_q.size() != 0) begin
            void'(host_q.pop_front());
            void'(host_be_q.pop_front());
        end
        if (ev_rxv) fpga_got.push_back(ev_rx_word);
        ev_tx_pop = 0; ev_host_acc = 0; ev_host_give = 0; ev_rxv = 0;
        #2;
        tx_valid_in = (tx_q.size() != 0);
        if (tx_q.size() != 0) begin
            tx_data_in = tx_q[0];
            tx_be_in   = tx_be_q[0];
        end else begin
            tx_data_in = '0;
            tx_be_in   = '0;
        end
        rxf_n_in = (host_q.size() == 0);
        if (host_q.size() != 0) begin
            data_in = host_q[0];
            be_in   = host_be_q[0];
        end else begin
            data_in = '0;
            be_in   = '0;
        end
    end

    // protocol model: phase of the current grant, words moved in it, last winner
    typedef enum {M_IDLE, M_WRITE, M_HANDOVER, M_READ, M_GAP} mphase_t;
    mphase_t     m_ph = M_IDLE;
    bit          m_last_tx = 0;
    int          m_words = 0;
    bit          m_rxv = 0;
    logic [31:0] m_rxd = '0;
    logic [3:0]  m_rxbe = '0;
    bit          e_wr, e_rd, e_oe, e_doe, e_pop, m_acc, m_take, m_treq, m_rreq;

    always @(negedge clk_in) begin
        if (!rst_in) begin
            m_ph = M_IDLE; m_last_tx = 0; m_words = 0;
            m_rxv = 0; m_rxd = '0; m_rxbe = '0;
        end
        e_wr = 1; e_rd = 1; e_oe = 1; e_doe = 0; e_pop = 0; m_acc = 0; m_take = 0;
        case (m_ph)
            M_WRITE: begin
                e_doe = 1;
                e_wr  = !tx_valid_in;
                m_acc = tx_valid_in && !txe_n_in;
                e_pop = m_acc;
            end
            M_HANDOVER: e_oe = 0;
            M_READ: begin
                e_oe   = 0;
                e_rd   = rx_full_in;
                m_take = !rx_full_in && !rxf_n_in;
            end
            default: ;
        endcase
        chk("wr_n", 32'(wr_n_out), 32'(e_wr));
        chk("rd_n", 32'(rd_n_out), 32'(e_rd));
        chk("oe_n", 32'(oe_n_out), 32'(e_oe));
        chk("data_oe", 32'(data_oe_out), 32'(e_doe));
        chk("tx_pop", 32'(tx_pop_out), 32'(e_pop));
        chk("rx_valid", 32'(rx_valid_out), 32'(m_rxv));
        chk("rx_data", rx_data_out, m_rxd);
        chk("rx_be", 32'(rx_be_out), 32'(m_rxbe));
        chk("no_wr_rd_overlap", 32'(!wr_n_out && !rd_n_out), 32'd0);
        chk("no_drive_with_oe", 32'(data_oe_out && !oe_n_out), 32'd0);
        if (e_doe && tx_valid_in) begin
            chk("data_out", data_out, tx_data_in);
            chk("be_out", 32'(be_out), 32'(tx_be_in));
        end

        ev_tx_pop    = tx_pop_out;
        ev_host_acc  = !wr_n_out && !txe_n_in;
        ev_host_word = data_out;
        ev_host_give = !rd_n_out && !rxf_n_in;
        ev_rxv       = rx_valid_out;
        ev_rx_word   = rx_data_out;

        if (!wr_n_out) cnt_wr_low++;
        if (!oe_n_out) cnt_oe_low++;
        if (!rd_n_out) cnt_rd_low++;
        if (rx_valid_out) cnt_rxv++;
        if (tx_pop_out) begin cnt_pop++; seq.push_back(8'h54); end
        if (!rd_n_out && !rxf_n_in) seq.push_back(8'h52);
        if (prev_doe && !data_oe_out) cnt_doe_fall++;
        prev_doe = data_oe_out;

        if (rst_in) begin
            m_rxv = m_take;
            if (m_take) begin m_rxd = data_in; m_rxbe = be_in; end
            case (m_ph)
                M_IDLE: begin
                    m_treq = tx_valid_in && !txe_n_in;
                    m_rreq = !rxf_n_in && !rx_full_in;
                    if (m_treq && (!m_rreq || !m_last_tx)) begin
                        m_ph = M_WRITE; m_last_tx = 1; m_words = 0;
                    end else if (m_rreq) begin
                        m_ph = M_HANDOVER; m_last_tx = 0; m_words = 0;
                    end
                end
                M_WRITE: begin
                    if (m_acc) m_words++;
                    if (!m_acc || m_words == MAXB) m_ph = M_GAP;
                end
                M_HANDOVER: m_ph = M_READ;
                M_READ: begin
                    if (m_take) m_words++;
                    if (!m_take || m_words == MAXB) m_ph = M_GAP;
                end
                default: m_ph = M_IDLE;
            endcase
        end
    end

    task automatic clear_stats();
        cnt_wr_low = 0; cnt_oe_low = 0; cnt_rd_low = 0; cnt_rxv = 0; cnt_pop = 0; cnt_doe_fall = 0;
        seq.delete();
    endtask

    task automatic do_reset();
        rst_in = 0;
        txe_n_in = 1;
        rx_full_in = 0;
        tx_q.delete(); tx_be_q.delete(); host_q.delete(); host_be_q.delete();
        tx_sent.delete(); host_sent.delete(); host_got.delete(); fpga_got.delete();
        tick(); tick();
        rst_in = 1;
        tick();
        clear_stats();
    endtask

    task automatic load_tx(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            tx_q.push_back(base + 32'(i));
            tx_be_q.push_back(4'(i + 1));
            tx_sent.push_back(base + 32'(i));
        end
    endtask

    task automatic load_host(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            host_q.push_back(base + 32'(i));
            host_be_q.push_back(4'(15 - i));
            host_sent.push_back(base + 32'(i));
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((tx_q.size() != 0 || host_q.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) chk({name, "_drain_timeout"}, 32'(n), 32'd0);
        repeat (4) tick();
    endtask

    task automatic wait_count(input string name, input bit host_side, input int target);
        int n = 0;
        while (((host_side ? host_got.size() : fpga_got.size()) < target) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk({name, "_wait_timeout"}, 32'(n), 32'd0);
    endtask

    task automatic sb_check(input string name);
        chk({name, "_tx_count"}, 32'(host_got.size()), 32'(tx_sent.size()));
        for (int i = 0; i < tx_sent.size(); i++)
            if (i < host_got.size()) chk({name, "_tx_word"}, host_got[i], tx_sent[i]);
        chk({name, "_rx_count"}, 32'(fpga_got.size()), 32'(host_sent.size()));
        for (int i = 0; i < host_sent.size(); i++)
            if (i < fpga_got.size()) chk({name, "_rx_word"}, fpga_got[i], host_sent[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string exp_seq;
        rst_in = 0; txe_n_in = 1; rx_full_in = 0;
        tx_valid_in = 0; tx_data_in = '0; tx_be_in = '0;
        rxf_n_in = 1; data_in = '0; be_in = '0;
        tick(); tick();
        chk("reset_wr_n", 32'(wr_n_out), 32'd1);
        chk("reset_rd_n", 32'(rd_n_out), 32'd1);
        chk("reset_oe_n", 32'(oe_n_out), 32'd1);
        chk("reset_data_oe", 32'(data_oe_out), 32'd0);
        chk("reset_rx_valid", 32'(rx_valid_out), 32'd0);
        chk("reset_rx_data", rx_data_out, 32'd0);

        // 10 TX words with MAX_BURST=4: bursts 4,4,2 separated by TURN
        do_reset();
        txe_n_in = 0;
        load_tx(10, 32'hA000_0000);
        drain("tx10");
        chk("tx10_wr_low", 32'(cnt_wr_low), 32'd10);
        chk("tx10_pops", 32'(cnt_pop), 32'd10);
        chk("tx10_bursts", 32'(cnt_doe_fall), 32'd3);
        sb_check("tx10");

        // TXE_N stall at the third word: one refused cycle, then regrant
        do_reset();
        txe_n_in = 0;
        load_tx(10, 32'hC000_0000);
        wait_count("stall", 1, 2);
        txe_n_in = 1;
        repeat (3) tick();
        txe_n_in = 0;
        drain("stall");
        chk("stall_wr_low", 32'(cnt_wr_low), 32'd11);
        chk("stall_pops", 32'(cnt_pop), 32'd10);
        chk("stall_bursts", 32'(cnt_doe_fall), 32'd3);
        sb_check("stall");

        // 5 RX words: bursts of 4 and 1, each preceded by one OE handover cycle
        do_reset();
        load_host(5, 32'hB000_0000);
        drain("rx5");
        chk("rx5_oe_low", 32'(cnt_oe_low), 32'd8);
        chk("rx5_rd_low", 32'(cnt_rd_low), 32'd6);
        chk("rx5_valid", 32'(cnt_rxv), 32'd5);
        sb_check("rx5");

        // both sides pending: grants alternate starting with TX
        do_reset();
        txe_n_in = 0;
        load_tx(8, 32'hD000_0000);
        load_host(8, 32'hE000_0000);
        drain("fair");
        exp_seq = "TTTTRRRRTTTTRRRR";
        chk("fair_len", 32'(seq.size()), 32'd16);
        for (int i = 0; i < 16; i++)
            if (i < seq.size()) chk("fair_seq", 32'(seq[i]), 32'(exp_seq[i]));
        chk("fair_tx_bursts", 32'(cnt_doe_fall), 32'd2);
        sb_check("fair");

        // RX FIFO goes almost-full mid burst
        do_reset();
        load_host(6, 32'h5000_0000);
        wait_count("rxfull", 0, 1);
        rx_full_in = 1;
        #1;
        chk("rxfull_rd_n_now", 32'(rd_n_out), 32'd1);
        repeat (3) tick();
        rx_full_in = 0;
        drain("rxfull");
        chk("rxfull_valid", 32'(cnt_rxv), 32'd6);
        sb_check("rxfull");

        // reset asserted mid TX burst
        do_reset();
        txe_n_in = 0;
        load_tx(12, 32'h7000_0000);
        wait_count("midrst", 1, 2);
        chk("midrst_wr_before", 32'(wr_n_out), 32'd0);
        rst_in = 0;
        #1;
        chk("midrst_wr_n", 32'(wr_n_out), 32'd1);
        chk("midrst_data_oe", 32'(data_oe_out), 32'd0);
        chk("midrst_pop", 32'(tx_pop_out), 32'd0);
        tick(); tick();
        rst_in = 1;
        #1;
        chk("midrst_idle_wr_n", 32'(wr_n_out), 32'd1);
        chk("midrst_idle_data_oe", 32'(data_oe_out), 32'd0);
        drain("midrst");
        sb_check("midrst");

`ifdef FT_SCHED_STATS_EN
        do_reset();
        txe_n_in = 0;
        load_tx(7, 32'h1000_0000);
        drain("stats_tx");
        load_host(3, 32'h2000_0000);
        drain("stats_rx");
        chk("stats_tx_words", tx_words_out, 32'd7);
        chk("stats_rx_words", rx_words_out, 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
